// File: rtl/monitor_scheduler.sv
// rtl/monitor_scheduler.sv - event queue and staged evaluation sequencer for a stream monitor
module monitor_scheduler #(
  parameter int DATA_W = 8,
  parameter int STAGES = 5,
  parameter int DEPTH  = 4,
  parameter int PERIOD = 500
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     input_a,
  input  logic                     input_b,
  input  logic                     new_input_a,
  input  logic                     new_input_b,
  input  logic                     new_input_id,
  input  logic signed [DATA_W-1:0] input_id,
  output logic                     hlc_a,
  output logic                     hlc_b,
  output logic signed [DATA_W-1:0] hlc_id,
  output logic [63:0]              hlc_clock_cnt,
  output logic                     hlc_en_lt,
  output logic                     hlc_en_gt,
  output logic                     hlc_en_neq,
  output logic                     hlc_en_not_a,
  output logic                     hlc_en_a_impl_b,
  output logic                     hlc_en_time_stream,
  output logic [2:0]               llc_stage,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic              a;
    logic              new_a;
    logic              b;
    logic              new_b;
    logic [DATA_W-1:0] id;
    logic              new_id;
    logic              periodic;
    logic [63:0]       ts;
  } entry_t;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  entry_t        mem [DEPTH];
  entry_t        wr_entry;
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [63:0]   time_cnt;
  logic [31:0]   tick_cnt;
  logic          tick, push_req, push_ok, pop, full, empty, last_stage;

  // A tick fires on the PERIOD-th enabled edge since reset and every PERIOD thereafter.
  assign tick       = en && (tick_cnt == 32'(PERIOD - 1));
  assign push_req   = en && (new_input_a || new_input_b || new_input_id || tick);
  assign full       = (q_count == CW'(DEPTH));
  assign empty      = (q_count == '0);
  assign last_stage = (llc_stage == 3'(STAGES - 1));
  // Pops run independently of en so an evaluation already started always drains.
  assign pop        = !empty && ((state_q == IDLE) || last_stage);
  // When full, a same-edge pop frees the slot the push lands in.
  assign push_ok    = push_req && (!full || pop);
  assign head       = mem[rd_ptr];
  assign busy       = (state_q == RUN);

  always_comb begin
    wr_entry          = '0;
    wr_entry.a        = input_a & new_input_a;
    wr_entry.new_a    = new_input_a;
    wr_entry.b        = input_b & new_input_b;
    wr_entry.new_b    = new_input_b;
    wr_entry.id       = new_input_id ? input_id : '0;
    wr_entry.new_id   = new_input_id;
    wr_entry.periodic = tick;
    wr_entry.ts       = time_cnt;
  end

  // Time and tick counters advance only on enabled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      time_cnt <= '0;
      tick_cnt <= '0;
    end else if (en) begin
      time_cnt <= time_cnt + 64'd1;
      tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;
    end
  end

  // Queue storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_entry;
  end

  // Queue pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      q_count  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      q_count <= q_count + 1'b1;
      else if (pop && !push_ok) q_count <= q_count - 1'b1;
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Sequencer next state: stay in RUN while entries keep arriving back-to-back.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = RUN;
      RUN:     if (last_stage && empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Held event registers and stage counter; enables stay fixed across an evaluation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hlc_a              <= 1'b0;
      hlc_b              <= 1'b0;
      hlc_id             <= '0;
      hlc_clock_cnt      <= '0;
      hlc_en_lt          <= 1'b0;
      hlc_en_gt          <= 1'b0;
      hlc_en_neq         <= 1'b0;
      hlc_en_not_a       <= 1'b0;
      hlc_en_a_impl_b    <= 1'b0;
      hlc_en_time_stream <= 1'b0;
      llc_stage          <= '0;
    end else if (pop) begin
      hlc_a              <= head.a;
      hlc_b              <= head.b;
      hlc_id             <= head.id;
      hlc_clock_cnt      <= head.ts;
      hlc_en_lt          <= head.new_a & head.new_b;
      hlc_en_gt          <= head.new_a & head.new_b;
      hlc_en_a_impl_b    <= head.new_a & head.new_b;
      hlc_en_not_a       <= head.new_a;
      hlc_en_neq         <= head.new_id;
      hlc_en_time_stream <= head.periodic;
      llc_stage          <= '0;
    end else if (state_q == RUN) begin
      if (last_stage) begin
        llc_stage          <= '0;
        hlc_en_lt          <= 1'b0;
        hlc_en_gt          <= 1'b0;
        hlc_en_neq         <= 1'b0;
        hlc_en_not_a       <= 1'b0;
        hlc_en_a_impl_b    <= 1'b0;
        hlc_en_time_stream <= 1'b0;
      end else begin
        llc_stage <= llc_stage + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_monitor_scheduler.sv
// tb/tb_monitor_scheduler.sv - directed self-checking bench for monitor_scheduler
module tb_monitor_scheduler;

  logic              clk, rst, en;
  logic              input_a, input_b, new_input_a, new_input_b, new_input_id;
  logic signed [7:0] input_id;
  logic              hlc_a, hlc_b;
  logic signed [7:0] hlc_id;
  logic [63:0]       hlc_clock_cnt;
  logic              hlc_en_lt, hlc_en_gt, hlc_en_neq, hlc_en_not_a, hlc_en_a_impl_b, hlc_en_time_stream;
  logic [2:0]        llc_stage;
  logic              busy;
  logic [2:0]        q_count;
  logic              overflow;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] tcnt;
  logic [63:0] t_exp;

  monitor_scheduler #(.DATA_W(8), .STAGES(5), .DEPTH(4), .PERIOD(500)) dut (
    .clk(clk), .rst(rst), .en(en),
    .input_a(input_a), .input_b(input_b),
    .new_input_a(new_input_a), .new_input_b(new_input_b), .new_input_id(new_input_id),
    .input_id(input_id),
    .hlc_a(hlc_a), .hlc_b(hlc_b), .hlc_id(hlc_id), .hlc_clock_cnt(hlc_clock_cnt),
    .hlc_en_lt(hlc_en_lt), .hlc_en_gt(hlc_en_gt), .hlc_en_neq(hlc_en_neq),
    .hlc_en_not_a(hlc_en_not_a), .hlc_en_a_impl_b(hlc_en_a_impl_b),
    .hlc_en_time_stream(hlc_en_time_stream),
    .llc_stage(llc_stage), .busy(busy), .q_count(q_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference time counter: enabled edges since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst)    tcnt <= 64'd0;
    else if (en) tcnt <= tcnt + 64'd1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of strobes; returns at the negedge after the push edge.
  task automatic pulse(input logic a, input logic b, input logic na, input logic nb,
                       input logic nid, input logic signed [7:0] id);
    input_a = a; input_b = b; new_input_a = na; new_input_b = nb;
    new_input_id = nid; input_id = id;
    @(negedge clk);
    input_a = 0; input_b = 0; new_input_a = 0; new_input_b = 0;
    new_input_id = 0; input_id = 0;
  endtask

  task automatic wait_time(input logic [63:0] target);
    for (int k = 0; k < 2000 && tcnt != target; k++) @(negedge clk);
  endtask

  initial begin
    rst = 0; en = 0;
    input_a = 0; input_b = 0; new_input_a = 0; new_input_b = 0; new_input_id = 0; input_id = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_stage", llc_stage, 0);
    chk("rst_qcount", q_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_clock_cnt", hlc_clock_cnt, 0);
    rst = 1;
    en = 1;
    repeat (2) @(negedge clk);

    // Single event with all strobes.
    t_exp = tcnt;
    pulse(1, 1, 1, 1, 1, 8'sd2);
    chk("single_queued", q_count, 1);
    @(negedge clk);
    chk("single_busy", busy, 1);
    chk("single_id", hlc_id, 2);
    chk("single_ts", hlc_clock_cnt, t_exp);
    chk("single_ens", {hlc_en_lt, hlc_en_gt, hlc_en_neq, hlc_en_not_a, hlc_en_a_impl_b, hlc_en_time_stream}, 6'b111110);
    chk("single_stage0", llc_stage, 0);
    for (int s = 1; s < 5; s++) begin
      @(negedge clk);
      chk("single_stage", llc_stage, s);
      chk("single_ens_hold", {hlc_en_lt, hlc_en_not_a, hlc_en_time_stream}, 3'b110);
    end
    @(negedge clk);
    chk("single_done_busy", busy, 0);
    chk("single_done_stage", llc_stage, 0);
    chk("single_done_en", {hlc_en_lt, hlc_en_neq, hlc_en_not_a}, 3'b000);

    // Partial strobes: only new_a and new_id.
    pulse(1, 1, 1, 0, 1, 8'sd4);
    @(negedge clk);
    chk("partial_ens", {hlc_en_lt, hlc_en_gt, hlc_en_neq, hlc_en_not_a, hlc_en_a_impl_b, hlc_en_time_stream}, 6'b001100);
    chk("partial_b", hlc_b, 0);
    chk("partial_a", hlc_a, 1);
    chk("partial_id", hlc_id, 4);
    repeat (5) @(negedge clk);
    // Id without its strobe is stored as zero.
    pulse(0, 1, 0, 1, 0, 8'sd7);
    @(negedge clk);
    chk("nostrobe_id", hlc_id, 0);
    chk("nostrobe_b", hlc_b, 1);
    repeat (5) @(negedge clk);

    // Periodic tick alone at time 499.
    wait_time(64'd499);
    chk("pre_tick_idle", {busy, q_count}, 4'b0000);
    @(negedge clk);
    chk("tick_queued", q_count, 1);
    @(negedge clk);
    chk("tick_ens", {hlc_en_lt, hlc_en_neq, hlc_en_not_a, hlc_en_time_stream}, 4'b0001);
    chk("tick_ts", hlc_clock_cnt, 499);
    repeat (5) @(negedge clk);
    chk("tick_done", busy, 0);

    // Input on the tick edge merges into one entry.
    wait_time(64'd999);
    pulse(1, 0, 1, 0, 0, 8'sd0);
    chk("merge_queued", q_count, 1);
    @(negedge clk);
    chk("merge_ens", {hlc_en_not_a, hlc_en_time_stream}, 2'b11);
    chk("merge_ts", hlc_clock_cnt, 999);
    repeat (5) @(negedge clk);
    chk("merge_single_eval", {busy, q_count}, 4'b0000);

    // Burst of 6: one popped, 4 queued, one dropped.
    for (int k = 1; k <= 6; k++) begin
      input_a = 1; new_input_a = 1; new_input_id = 1; input_id = 8'(k);
      @(negedge clk);
    end
    new_input_a = 0; new_input_id = 0; input_a = 0; input_id = 0;
    chk("burst_full", q_count, 4);
    chk("burst_overflow", overflow, 1);
    chk("burst_stage", llc_stage, 4);
    chk("burst_first_id", hlc_id, 1);
    for (int e = 2; e <= 5; e++) begin
      for (int s = 0; s < 5; s++) begin
        @(negedge clk);
        chk("burst_busy", busy, 1);
        chk("burst_stage_seq", llc_stage, s);
        if (s == 0) chk("burst_id", hlc_id, e);
      end
    end
    @(negedge clk);
    chk("burst_done", {busy, q_count}, 4'b0000);
    chk("burst_overflow_sticky", overflow, 1);

    // en gating: running evaluation completes, timer holds, strobes ignored.
    pulse(1, 1, 1, 1, 0, 8'sd0);
    @(negedge clk);
    chk("gate_busy", busy, 1);
    en = 0;
    t_exp = tcnt;
    for (int k = 1; k <= 100; k++) begin
      if (k == 10) begin input_a = 1; new_input_a = 1; end
      if (k == 11) begin input_a = 0; new_input_a = 0; end
      @(negedge clk);
      if (k < 5) chk("gate_stage", llc_stage, k);
      if (k == 5) chk("gate_done", busy, 0);
    end
    chk("gate_ignored", {busy, q_count}, 4'b0000);
    en = 1;
    pulse(0, 0, 0, 0, 1, 8'sd9);
    @(negedge clk);
    chk("gate_ts_held", hlc_clock_cnt, t_exp);
    repeat (5) @(negedge clk);
    chk("overflow_before_rst", overflow, 1);

    // Reset at stage 2 with two entries queued.
    for (int k = 1; k <= 3; k++) pulse(0, 0, 0, 0, 1, 8'(k));
    @(negedge clk);
    chk("midrun_stage", llc_stage, 2);
    chk("midrun_q", q_count, 2);
    rst = 0;
    #1;
    chk("arst_outs", {busy, llc_stage, q_count, overflow, hlc_en_neq}, 9'd0);
    chk("arst_id", hlc_id, 0);
    chk("arst_ts", hlc_clock_cnt, 0);
    @(negedge clk);
    rst = 1;
    repeat (10) @(negedge clk);
    chk("post_rst_idle", {busy, q_count, llc_stage}, 7'd0);
    t_exp = tcnt;
    pulse(0, 0, 0, 0, 1, 8'sd5);
    @(negedge clk);
    chk("post_rst_id", hlc_id, 5);
    chk("post_rst_ts", hlc_clock_cnt, t_exp);
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/monitor_scheduler.md
MONITOR_SCHEDULER -- requirements
Module: monitor_scheduler

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, meaning the width of the signed id input and its replay output.
REQ-002 The module SHALL have parameter STAGES, default 5, meaning the number of low-level evaluation stages per event (2..8).
REQ-003 The module SHALL have parameter DEPTH, default 4, meaning the number of pending-event queue entries (power of 2).
REQ-004 The module SHALL have parameter PERIOD, default 500, meaning the periodic tick interval in enabled clock cycles.
REQ-005 The module SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 The module SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-007 The module SHALL have port en  input  1  global enable; when low, the time counter, the tick counter and event acceptance freeze.
REQ-008 The module SHALL have ports input_a, input_b  input  1 each  boolean stream values.
REQ-009 The module SHALL have ports new_input_a, new_input_b, new_input_id  input  1 each  fresh-value strobes.
REQ-010 The module SHALL have port input_id  input  DATA_W  signed id value.
REQ-011 The module SHALL have ports hlc_a, hlc_b  output  1 each  held event values.
REQ-012 The module SHALL have port hlc_id  output  DATA_W  held event value.
REQ-013 The module SHALL have port hlc_clock_cnt  output  64  timestamp of the held event.
REQ-014 The module SHALL have ports hlc_en_lt, hlc_en_gt, hlc_en_neq, hlc_en_not_a, hlc_en_a_impl_b, hlc_en_time_stream  output  1 each  stream enables of the held event.
REQ-015 The module SHALL have port llc_stage  output  3  current evaluation stage.
REQ-016 The module SHALL have port busy  output  1  high while an event is being evaluated.
REQ-017 The module SHALL have port q_count  output  clog2(DEPTH)+1  number of queued entries.
REQ-018 The module SHALL have port overflow  output  1  sticky dropped-event flag.

Function
REQ-019 A free-running 64-bit time counter SHALL increment by 1 each cycle with en=1 and wrap from 2^64-1 to 0.
REQ-020 A tick counter SHALL count enabled cycles and generate a tick every PERIOD cycles, with the first tick at enabled cycle PERIOD after reset.
REQ-021 A push SHALL occur on an edge with en=1 and (any new_input_* high, or a tick).
REQ-022 A simultaneous tick and input event SHALL merge into one entry with the periodic flag set.
REQ-023 Each queue entry SHALL store {a, new_a, b, new_b, id, new_id, periodic, time counter value at push}.
REQ-024 Values whose new_* strobe is low SHALL be stored as 0.
REQ-025 The sequencer SHALL have states IDLE and RUN.
REQ-026 In IDLE with q_count>0, the next edge SHALL pop the head into the held registers and enter RUN with llc_stage=0 and busy=1.
REQ-027 An entry pushed into an empty queue at edge T SHALL be held from edge T+1.
REQ-028 In RUN, llc_stage SHALL increment by 1 per clock regardless of en.
REQ-029 At llc_stage=STAGES-1, the next edge SHALL pop the next entry with llc_stage=0 if q_count>0 (back-to-back, no bubble); otherwise the sequencer SHALL enter IDLE with busy=0, llc_stage=0 and all hlc_en_* = 0.
REQ-030 hlc_en_lt, hlc_en_gt and hlc_en_a_impl_b SHALL equal new_a AND new_b of the held entry.
REQ-031 hlc_en_not_a SHALL equal new_a, hlc_en_neq SHALL equal new_id and hlc_en_time_stream SHALL equal periodic.
REQ-032 All hlc_en_* SHALL be held constant for all STAGES cycles of an evaluation.
REQ-033 On a push and a pop in the same edge, both SHALL complete and q_count SHALL remain unchanged, including when the queue is full.
REQ-034 On a push when full with no pop, the entry SHALL be dropped and overflow SHALL set; overflow SHALL clear only on reset.
REQ-035 All outputs SHALL be registered.

Reset
REQ-036 On rst=0, all outputs SHALL be forced asynchronously to 0, including hlc_clock_cnt, llc_stage, busy, q_count and overflow.
REQ-037 On rst=0, the queue SHALL be emptied and the time and tick counters SHALL be cleared.
REQ-038 On rst=0 during RUN, the in-flight evaluation SHALL be abandoned and SHALL NOT resume after reset release.
REQ-039 After deassertion, the first rising edge SHALL operate normally.

Verification
REQ-040 Scenario single event: en=1; a=1, b=1, id=2 with all strobes for one cycle at time counter t -> hlc_id=2 and hlc_clock_cnt=t; lt/gt/neq/not_a/a_impl_b enables=1 and time_stream=0; llc_stage goes 0,1,2,3,4, then busy=0.
REQ-041 Scenario partial strobes: new_a=1 and new_id=1 only, with id=4 -> hlc_en_not_a=1 and hlc_en_neq=1, other enables=0, hlc_b=0.
REQ-042 Scenario periodic: no inputs for 500 enabled cycles -> exactly one evaluation with only hlc_en_time_stream=1; an input strobe on the tick cycle -> one merged evaluation, not two.
REQ-043 Scenario burst/overflow: 6 events on consecutive cycles, DEPTH=4 -> 5 evaluations back-to-back (one popped, 4 queued) with llc_stage never idling between them, one event dropped, overflow=1 until reset.
REQ-044 Scenario en gating: en=0 for 100 cycles -> the time counter holds and strobes are ignored; an evaluation already in RUN completes all 5 stages.
REQ-045 Scenario reset mid-run: rst=0 at llc_stage=2 with 2 entries queued -> all outputs 0 immediately; after release, q_count=0 and no evaluation occurs until a new push.
